// File: rtl/seven_segment_mux_counter.sv
// rtl/seven_segment_mux_counter.sv - N-digit BCD up/down counter with multiplexed common-anode 7-segment drive
module seven_segment_mux_counter #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 100_000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  dp,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  wrap
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]          presc;
  logic                   tick;
  logic [4*DIGITS-1:0]    count_nxt;
  logic                   carry_out;
  logic [SW-1:0]          scan_cnt;
  logic [IW-1:0]          idx;
  logic [3:0]             cur_digit;
  logic                   cur_blank;
  logic [DIGITS-1:0]      an_nxt;

  assign tick = en && (presc == PW'(TICK_DIV - 1));

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    case (d)
      4'd0:    seg_pat = 7'b1000000;
      4'd1:    seg_pat = 7'b1111001;
      4'd2:    seg_pat = 7'b0100100;
      4'd3:    seg_pat = 7'b0110000;
      4'd4:    seg_pat = 7'b0011001;
      4'd5:    seg_pat = 7'b0010010;
      4'd6:    seg_pat = 7'b0000010;
      4'd7:    seg_pat = 7'b1111000;
      4'd8:    seg_pat = 7'b0000000;
      4'd9:    seg_pat = 7'b0010000;
      default: seg_pat = 7'b1111111;
    endcase
  endfunction

  // Ripple carry/borrow through the digits; a carry out of the top digit is a wrap.
  always_comb begin
    logic cy;
    count_nxt = count_bcd;
    cy = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (cy) begin
        if (up) begin
          if (count_bcd[4*k +: 4] >= 4'd9) begin
            count_nxt[4*k +: 4] = 4'd0;
          end else begin
            count_nxt[4*k +: 4] = count_bcd[4*k +: 4] + 4'd1;
            cy = 1'b0;
          end
        end else begin
          if (count_bcd[4*k +: 4] == 4'd0) begin
            count_nxt[4*k +: 4] = 4'd9;
          end else begin
            count_nxt[4*k +: 4] = count_bcd[4*k +: 4] - 4'd1;
            cy = 1'b0;
          end
        end
      end
    end
    carry_out = cy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      count_bcd <= '0;
      wrap      <= 1'b0;
    end else if (clr) begin
      presc     <= '0;
      count_bcd <= '0;
      wrap      <= 1'b0;
    end else begin
      wrap <= tick && carry_out;
      if (tick) begin
        count_bcd <= count_nxt;
      end
      if (en) begin
        presc <= tick ? '0 : presc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // lz tracks "this digit and everything above it is zero", scanning from the top down.
  always_comb begin
    logic lz;
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    an_nxt    = '1;
    lz        = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lz = lz && (count_bcd[4*k +: 4] == 4'd0);
      if (idx == IW'(k)) begin
        cur_digit = count_bcd[4*k +: 4];
        cur_blank = BLANK_LZ && lz && (k > 0);
        an_nxt[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= 7'h7F;
      an  <= '1;
      dp  <= 1'b1;
    end else begin
      seg <= cur_blank ? 7'h7F : seg_pat(cur_digit);
      an  <= an_nxt;
      dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seven_segment_mux_counter.sv
// tb/tb_seven_segment_mux_counter.sv - randomized check of seven_segment_mux_counter against an integer reference model
module tb_seven_segment_mux_counter;

  localparam int TD  = 4;
  localparam int SD  = 2;
  localparam int D   = 4;
  localparam int MOD = 10000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic up = 1'b0;
  logic clr = 1'b0;

  logic [6:0]  seg4, seg4n, seg1;
  logic [3:0]  an4, an4n;
  logic [0:0]  an1;
  logic        dp4, dp4n, dp1;
  logic [15:0] cnt4, cnt4n;
  logic [3:0]  cnt1;
  logic        wrap4, wrap4n, wrap1;

  always #5 clk = ~clk;

  seven_segment_mux_counter #(.DIGITS(4), .TICK_DIV(TD), .SCAN_DIV(SD), .BLANK_LZ(1'b1)) u_blank (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr),
    .seg(seg4), .an(an4), .dp(dp4), .count_bcd(cnt4), .wrap(wrap4));

  seven_segment_mux_counter #(.DIGITS(4), .TICK_DIV(TD), .SCAN_DIV(SD), .BLANK_LZ(1'b0)) u_noblank (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr),
    .seg(seg4n), .an(an4n), .dp(dp4n), .count_bcd(cnt4n), .wrap(wrap4n));

  seven_segment_mux_counter #(.DIGITS(1), .TICK_DIV(TD), .SCAN_DIV(SD), .BLANK_LZ(1'b1)) u_one (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr),
    .seg(seg1), .an(an1), .dp(dp1), .count_bcd(cnt1), .wrap(wrap1));

  logic [6:0] pat [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  int checks = 0;
  int errors = 0;

  int m_val, m_val1, m_pc, m_n;
  logic m_wrap, m_wrap1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    for (int k = 0; k < D; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int k, input bit bl);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (bl && k > 0 && v < p) return 7'h7F;
    return pat[(v / p) % 10];
  endfunction

  task automatic model_reset();
    m_val = 0; m_val1 = 0; m_pc = 0; m_n = 0;
    m_wrap = 1'b0; m_wrap1 = 1'b0;
  endtask

  task automatic step(input logic e, input logic u, input logic c);
    int idx_old, v_old, v1_old;
    logic [3:0] ean;
    en = e; up = u; clr = c;
    idx_old = (m_n / SD) % D;
    v_old   = m_val;
    v1_old  = m_val1;
    @(posedge clk);
    if (c) begin
      m_val = 0; m_val1 = 0; m_pc = 0; m_wrap = 1'b0; m_wrap1 = 1'b0;
    end else if (e && m_pc == TD - 1) begin
      m_pc = 0;
      if (u) begin
        m_wrap  = (m_val == MOD - 1);
        m_wrap1 = (m_val1 == 9);
        m_val   = (m_val + 1) % MOD;
        m_val1  = (m_val1 + 1) % 10;
      end else begin
        m_wrap  = (m_val == 0);
        m_wrap1 = (m_val1 == 0);
        m_val   = (m_val + MOD - 1) % MOD;
        m_val1  = (m_val1 + 9) % 10;
      end
    end else begin
      if (e) m_pc++;
      m_wrap = 1'b0; m_wrap1 = 1'b0;
    end
    m_n++;
    #1;
    ean = ~(4'b0001 << idx_old);
    check_eq("count", 32'(cnt4), 32'(to_bcd(m_val)));
    check_eq("wrap", 32'(wrap4), 32'(m_wrap));
    check_eq("an", 32'(an4), 32'(ean));
    check_eq("seg_blank", 32'(seg4), 32'(exp_seg(v_old, idx_old, 1'b1)));
    check_eq("dp", 32'(dp4), 32'd1);
    check_eq("an_noblank", 32'(an4n), 32'(ean));
    check_eq("seg_noblank", 32'(seg4n), 32'(exp_seg(v_old, idx_old, 1'b0)));
    check_eq("count1", 32'(cnt1), 32'(m_val1));
    check_eq("wrap1", 32'(wrap1), 32'(m_wrap1));
    check_eq("an1", 32'(an1), 32'd0);
    check_eq("seg1", 32'(seg1), 32'(pat[v1_old]));
  endtask

  task automatic ticks(input logic u, input int n);
    for (int i = 0; i < n * TD; i++) step(1'b1, u, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_seg"}, 32'(seg4), 32'h7F);
    check_eq({tag, "_an"}, 32'(an4), 32'hF);
    check_eq({tag, "_count"}, 32'(cnt4), 32'h0);
    check_eq({tag, "_wrap"}, 32'(wrap4), 32'h0);
    check_eq({tag, "_dp"}, 32'(dp4), 32'h1);
    check_eq({tag, "_an1"}, 32'(an1), 32'h1);
    check_eq({tag, "_seg1"}, 32'(seg1), 32'h7F);
  endtask

  initial begin
    model_reset();
    #12;
    check_reset_state("rst_init");
    @(negedge clk);
    rst_n = 1'b1;

    // count to 0042, then async reset mid-cycle
    ticks(1'b1, 42);
    step(1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_state("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // 40 ticks up through 0009->0010 carries, then hold with en=0
    ticks(1'b1, 40);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
    check_eq("count_40", 32'(cnt4), 32'h0040);

    // wrap both directions
    step(1'b0, 1'b0, 1'b1);
    ticks(1'b0, 1);
    check_eq("down_wrap_val", 32'(cnt4), 32'h9999);
    ticks(1'b1, 1);
    check_eq("up_wrap_val", 32'(cnt4), 32'h0000);

    // 0099 -> 0100 carry, then clr coincident with tick at 0057
    step(1'b0, 1'b0, 1'b1);
    ticks(1'b1, 100);
    check_eq("count_100", 32'(cnt4), 32'h0100);
    step(1'b0, 1'b0, 1'b1);
    ticks(1'b1, 57);
    for (int i = 0; i < TD - 1; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check_eq("clr_tick_count", 32'(cnt4), 32'h0000);
    check_eq("clr_tick_wrap", 32'(wrap4), 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);

    // blanking at 0007, full display at 0305
    ticks(1'b1, 7);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    ticks(1'b1, 305);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, $urandom % 2 == 1, ($urandom % 64) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
